prod_accumulator: RTL and testbench



---
 rtl/prod_acc_pkg.sv | 14 +
 rtl/prod_acc_core.sv | 54 +++++
 rtl/prod_accumulator.sv | 81 ++++++++
 tb/tb_prod_accumulator.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/prod_acc_pkg.sv
// Shared types and constants for the product accumulator and the multiplier stage
// feeding it.
package prod_acc_pkg;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  localparam int ACC_W_DEF   = 8;
  localparam int N_TERMS_DEF = 4;
  localparam int PROD_W      = 4;

endpackage

// File: rtl/prod_acc_core.sv
// Accumulation datapath: running sum, sticky carry-out flag and term counter.
// It clears itself on the final beat of a frame or on clear.
module prod_acc_core
  import prod_acc_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int N_TERMS = N_TERMS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_beat,
  input  logic [PROD_W-1:0] i_prod,
  output logic [ACC_W-1:0]  o_sum_nxt,
  output logic              o_ovf_nxt,
  output logic              o_last
);

  localparam int              CNT_W    = $clog2(N_TERMS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);

  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W:0]   w_add;

  // One extra bit on the adder captures the carry out of ACC_W.
  assign w_add     = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_prod};
  assign o_sum_nxt = w_add[ACC_W-1:0];
  assign o_ovf_nxt = r_ovf | w_add[ACC_W];
  assign o_last    = (r_cnt == CNT_LAST);

  // Running sum, overflow flag and term counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= {ACC_W{1'b0}};
      r_ovf <= 1'b0;
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_clear || (i_beat && o_last)) begin
      r_acc <= {ACC_W{1'b0}};
      r_ovf <= 1'b0;
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_beat) begin
      r_acc <= o_sum_nxt;
      r_ovf <= o_ovf_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_acc <= r_acc;
      r_ovf <= r_ovf;
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/prod_accumulator.sv
// Sums N_TERMS products from the 2x2 multiplier into one result.
// The result is presented on a registered valid/ready port together with an overflow flag.
module prod_accumulator
  import prod_acc_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int N_TERMS = N_TERMS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  state_t           r_state;
  logic [ACC_W-1:0] r_out_sum;
  logic             r_out_ovf;
  logic             w_beat;
  logic [ACC_W-1:0] w_sum_nxt;
  logic             w_ovf_nxt;
  logic             w_last;

  // Handshake flags decode from the state register only, so they have no input-to-output path.
  assign in_ready  = (r_state == ACC);
  assign out_valid = (r_state == DONE);
  assign out_sum   = r_out_sum;
  assign out_ovf   = r_out_ovf;
  assign w_beat    = in_valid & in_ready & ~clear;

  prod_acc_core #(
    .ACC_W   (ACC_W),
    .N_TERMS (N_TERMS)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (clear),
    .i_beat    (w_beat),
    .i_prod    (in_prod),
    .o_sum_nxt (w_sum_nxt),
    .o_ovf_nxt (w_ovf_nxt),
    .o_last    (w_last)
  );

  // Handshake FSM and result registers; clear aborts any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ACC;
      r_out_sum <= {ACC_W{1'b0}};
      r_out_ovf <= 1'b0;
    end else if (clear) begin
      r_state   <= ACC;
    end else begin
      case (r_state)
        ACC: begin
          if (w_beat && w_last) begin
            r_out_sum <= w_sum_nxt;
            r_out_ovf <= w_ovf_nxt;
            r_state   <= DONE;
          end else begin
            r_state   <= ACC;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= ACC;
          end else begin
            r_state <= DONE;
          end
        end
        default: r_state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accumulator.sv
// Self-checking bench: two instances (ACC_W=8 and ACC_W=5, N_TERMS=4) share the same
// stimulus and are checked against a frame-level integer model.
module tb_prod_accumulator;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [3:0] in_prod;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_out_ovf;
  logic [7:0] a_out_sum;
  logic       b_in_ready, b_out_valid, b_out_ovf;
  logic [4:0] b_out_sum;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: products in the current frame and the last completed frame total.
  int m_cnt   = 0;
  int m_total = 0;
  int m_res   = 0;
  bit m_pend  = 1'b0;

  always #5 clk = ~clk;

  prod_accumulator #(.ACC_W(8), .N_TERMS(N)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_prod(in_prod),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_sum(a_out_sum), .out_ovf(a_out_ovf)
  );

  prod_accumulator #(.ACC_W(5), .N_TERMS(N)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_prod(in_prod),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_sum(b_out_sum), .out_ovf(b_out_ovf)
  );

  task automatic model_reset();
    m_cnt = 0; m_total = 0; m_res = 0; m_pend = 1'b0;
  endtask

  // Apply inputs for one cycle, advance the model, sample 1 time unit after the edge.
  task automatic step(input bit v, input int p, input bit ordy, input bit clr);
    in_valid = v; in_prod = 4'(p); out_ready = ordy; clear = clr;
    if (clr) begin
      m_cnt = 0; m_total = 0; m_pend = 1'b0;
    end else if (m_pend) begin
      if (ordy) m_pend = 1'b0;
    end else if (v) begin
      m_total += p;
      m_cnt++;
      if (m_cnt == N) begin
        m_res = m_total; m_pend = 1'b1; m_total = 0; m_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_tests++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_sum !== 8'd0 || a_out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a: rdy=%b vld=%b sum=%0d ovf=%b, want 1 0 0 0", a_in_ready, a_out_valid, a_out_sum, a_out_ovf);
    end
    n_tests++;
    if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_out_sum !== 5'd0 || b_out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_b: rdy=%b vld=%b sum=%0d ovf=%b, want 1 0 0 0", b_in_ready, b_out_valid, b_out_sum, b_out_ovf);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 9, 1'b1, 1'b0);
      n_tests++;
      if (a_out_valid !== (i == 3)) begin
        n_fail++;
        $display("FAIL b2b_valid beat%0d: got %b want %b", i, a_out_valid, (i == 3));
      end
    end
    n_tests++;
    if (a_out_sum !== 8'd36 || a_out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_sum8: got %0d/%b want 36/0", a_out_sum, a_out_ovf);
    end
    n_tests++;
    if (b_out_valid !== 1'b1 || b_out_sum !== 5'd4 || b_out_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_sum5: got v%b %0d/%b want v1 4/1", b_out_valid, b_out_sum, b_out_ovf);
    end
    step(1'b0, 0, 1'b1, 1'b0);
    n_tests++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: rdy=%b vld=%b want 1 0", a_in_ready, a_out_valid);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b0, 1'b0);
    n_tests++;
    if (b_out_valid !== 1'b1 || b_out_sum !== 5'd4 || b_out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ones5: got v%b %0d/%b want v1 4/0", b_out_valid, b_out_sum, b_out_ovf);
    end
    step(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (a_out_valid !== 1'b1 || a_out_sum !== 8'd10 || a_in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stall cyc%0d: vld=%b sum=%0d rdy=%b want 1 10 0", i, a_out_valid, a_out_sum, a_in_ready);
      end
      step(1'b1, $urandom_range(0, 9), 1'b0, 1'b0);
    end
    step(1'b0, 0, 1'b1, 1'b0);
    n_tests++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept: rdy=%b vld=%b want 1 0", a_in_ready, a_out_valid);
    end
  endtask

  task automatic test_bubbles();
    int vals[7] = '{2, -1, 3, -1, -1, 4, 6};
    for (int i = 0; i < 7; i++) begin
      step(vals[i] >= 0, (vals[i] >= 0) ? vals[i] : $urandom_range(0, 9), 1'b0, 1'b0);
      n_tests++;
      if (a_out_valid !== (i == 6)) begin
        n_fail++;
        $display("FAIL bubble_valid slot%0d: got %b want %b", i, a_out_valid, (i == 6));
      end
    end
    n_tests++;
    if (a_out_sum !== 8'd15) begin
      n_fail++;
      $display("FAIL bubble_sum: got %0d want 15", a_out_sum);
    end
    step(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_clear();
    step(1'b1, 9, 1'b0, 1'b0);
    step(1'b1, 9, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 1, 1'b0, 1'b0);
    step(1'b1, 0, 1'b0, 1'b0);
    step(1'b1, 4, 1'b0, 1'b0);
    step(1'b1, 4, 1'b0, 1'b0);
    n_tests++;
    if (a_out_valid !== 1'b1 || a_out_sum !== 8'd9) begin
      n_fail++;
      $display("FAIL clear_sum: vld=%b sum=%0d want 1 9", a_out_valid, a_out_sum);
    end
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 5, 1'b1, 1'b1);
    n_tests++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_done: vld=%b rdy=%b want 0 1", a_out_valid, a_in_ready);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 2, 1'b0, 1'b0);
    n_tests++;
    if (a_out_valid !== 1'b1 || a_out_sum !== 8'd8) begin
      n_fail++;
      $display("FAIL clear_after: vld=%b sum=%0d want 1 8", a_out_valid, a_out_sum);
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b1, 3, 1'b0, 1'b0);
    step(1'b1, 3, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_sum !== 8'd0 || a_out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: rdy=%b vld=%b sum=%0d ovf=%b want 1 0 0 0", a_in_ready, a_out_valid, a_out_sum, a_out_ovf);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 3, 1'b0, 1'b0);
    n_tests++;
    if (a_out_valid !== 1'b1 || a_out_sum !== 8'd12) begin
      n_fail++;
      $display("FAIL async_frame: vld=%b sum=%0d want 1 12", a_out_valid, a_out_sum);
    end
    step(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, $urandom_range(0, 15), $urandom % 2, $urandom_range(0, 19) == 0);
      n_tests++;
      if (a_in_ready !== !m_pend || a_out_valid !== m_pend || b_in_ready !== !m_pend || b_out_valid !== m_pend) begin
        n_fail++;
        if (errs++ < 10)
          $display("FAIL rand_hs cyc%0d: a %b/%b b %b/%b want rdy=%b vld=%b", i, a_in_ready, a_out_valid, b_in_ready, b_out_valid, !m_pend, m_pend);
      end
      if (m_pend) begin
        n_tests++;
        if (a_out_sum !== 8'(m_res % 256) || a_out_ovf !== (m_res >= 256) ||
            b_out_sum !== 5'(m_res % 32) || b_out_ovf !== (m_res >= 32)) begin
          n_fail++;
          if (errs++ < 10)
            $display("FAIL rand_res cyc%0d: a %0d/%b b %0d/%b want total %0d", i, a_out_sum, a_out_ovf, b_out_sum, b_out_ovf, m_res);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_prod = 4'd0; out_ready = 1'b0;
    model_reset();
    #12 rst_n = 1'b1;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_bubbles();
    test_clear();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
